// File: rtl/dft_pkg.sv
// Shared state encoding, default sizing and twiddle indexing for the DFT stream engine.
package dft_pkg;

    typedef enum logic [1:0] {IDLE, FILL, COMPUTE, OUTPUT} state_e;

    localparam int DEF_N_POINTS = 128;
    localparam int DEF_N_BINS   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_COEF_W   = 16;

    function automatic int addr_width(input int n_points);
        return $clog2(n_points);
    endfunction

    // Wide enough that N full-scale products can never overflow.
    function automatic int acc_width(input int data_w, input int coef_w, input int n_points);
        return data_w + coef_w + addr_width(n_points);
    endfunction

    // N is a power of two, so (k*n) mod N is just the low log2(N) bits of the product.
    function automatic int unsigned tw_idx(input int unsigned k, input int unsigned n,
                                           input int unsigned n_points);
        return (k * n) & (n_points - 1);
    endfunction

endpackage

// File: rtl/dft_cmac.sv
// Real x complex MAC: registered products, then accumulate re += x*cos, im -= x*sin.
module dft_cmac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 39
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [COEF_W-1:0] cos,
    input  logic [COEF_W-1:0] sin,
    output logic [ACC_W-1:0]  re_acc,
    output logic [ACC_W-1:0]  im_acc
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] pr_q, pi_q;
    logic signed [ACC_W-1:0]  re_q, im_q;
    logic                     vld_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= 1'b0;
            re_q  <= '0;
            im_q  <= '0;
        end else begin
            vld_q <= en;
            if (vld_q) begin
                re_q <= re_q + ACC_W'(pr_q);
                im_q <= im_q - ACC_W'(pi_q);
            end
        end
        if (en) begin
            pr_q <= PROD_W'($signed(x)) * PROD_W'($signed(cos));
            pi_q <= PROD_W'($signed(x)) * PROD_W'($signed(sin));
        end
    end

    assign re_acc = re_q;
    assign im_acc = im_q;

endmodule

// File: rtl/dft_stream_engine.sv
// Frame-buffered fixed-point DFT against a run-time twiddle table, results streamed per bin.
// Define DFT_MAG_EN to add a registered m_mag = re^2 + im^2 output (one extra cycle per bin).
module dft_stream_engine
    import dft_pkg::*;
#(
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int N_BINS   = DEF_N_BINS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int OUT_W    = DATA_W + $clog2(N_POINTS) + 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [DATA_W-1:0]                             s_data,
    input  logic                                          coef_we,
    input  logic [$clog2(N_POINTS)-1:0]                   coef_addr,
    input  logic [COEF_W-1:0]                             coef_cos,
    input  logic [COEF_W-1:0]                             coef_sin,
    output logic                                          coef_err,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [((N_BINS > 1) ? $clog2(N_BINS) : 1)-1:0] m_bin,
    output logic [OUT_W-1:0]                              m_re,
    output logic [OUT_W-1:0]                              m_im,
    output logic                                          m_last,
`ifdef DFT_MAG_EN
    output logic [2*OUT_W-1:0]                            m_mag,
`endif
    output logic                                          busy
);

    localparam int ADDR_W = addr_width(N_POINTS);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, N_POINTS);
    localparam int BIN_W  = (N_BINS > 1) ? $clog2(N_BINS) : 1;
    localparam int CNT_W  = ADDR_W + 2;
`ifdef DFT_MAG_EN
    localparam int LAT    = N_POINTS + 3;
`else
    localparam int LAT    = N_POINTS + 2;
`endif

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               coef_err_q, rd_vld_q, start;
    logic               s_fire, m_fire;
    logic [ADDR_W-1:0]  rd_n, tw_a;
    logic [DATA_W-1:0]  x_q;
    logic [COEF_W-1:0]  cos_q, sin_q;
    logic [ACC_W-1:0]   re_acc, im_acc;
    logic [OUT_W-1:0]   re_t, im_t;
    logic               unused_lsb;

    logic [DATA_W-1:0]  xbuf    [N_POINTS];
    logic [COEF_W-1:0]  cos_mem [N_POINTS];
    logic [COEF_W-1:0]  sin_mem [N_POINTS];

    assign busy    = (state_q == COMPUTE) || (state_q == OUTPUT);
    assign s_ready = !busy;
    assign m_valid = (state_q == OUTPUT);
    assign s_fire  = s_valid && s_ready;
    assign m_fire  = m_valid && m_ready;
    assign rd_n    = cnt_q[ADDR_W-1:0];
    assign tw_a    = ADDR_W'(tw_idx(32'(bin_q), 32'(rd_n), N_POINTS));

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        start   = 1'b0;
        case (state_q)
            IDLE, FILL: if (s_fire) begin
                fill_d  = fill_q + ADDR_W'(1);
                state_d = FILL;
                if (fill_q == ADDR_W'(N_POINTS - 1)) begin
                    state_d = COMPUTE;
                    start   = 1'b1;
                    cnt_d   = '0;
                    bin_d   = '0;
                end
            end
            COMPUTE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LAT - 1)) state_d = OUTPUT;
            end
            OUTPUT: if (m_fire) begin
                if (bin_q == BIN_W'(N_BINS - 1)) begin
                    state_d = IDLE;
                    bin_d   = '0;
                end else begin
                    state_d = COMPUTE;
                    bin_d   = bin_q + BIN_W'(1);
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fill_q     <= '0;
            cnt_q      <= '0;
            bin_q      <= '0;
            coef_err_q <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            coef_err_q <= coef_we && busy;
            rd_vld_q   <= (state_q == COMPUTE) && (cnt_q < CNT_W'(N_POINTS));
        end
    end

    // Sample buffer and twiddle table: one write port, one registered read port each.
    always_ff @(posedge clk) begin
        if (s_fire && !reset) xbuf[fill_q] <= s_data;
        if (coef_we && !busy && !reset) begin
            cos_mem[coef_addr] <= coef_cos;
            sin_mem[coef_addr] <= coef_sin;
        end
        x_q   <= xbuf[rd_n];
        cos_q <= cos_mem[tw_a];
        sin_q <= sin_mem[tw_a];
    end

    dft_cmac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_cmac (
        .clk    (clk),
        .clr    (reset || start),
        .en     (rd_vld_q),
        .x      (x_q),
        .cos    (cos_q),
        .sin    (sin_q),
        .re_acc (re_acc),
        .im_acc (im_acc)
    );

    // Dropping the low COEF_W-1 bits is an arithmetic shift, i.e. floor rounding.
    assign re_t       = re_acc[COEF_W-1 +: OUT_W];
    assign im_t       = im_acc[COEF_W-1 +: OUT_W];
    assign unused_lsb = ^{re_acc[COEF_W-2:0], im_acc[COEF_W-2:0]};

    assign m_re     = m_valid ? re_t : '0;
    assign m_im     = m_valid ? im_t : '0;
    assign m_bin    = m_valid ? bin_q : '0;
    assign m_last   = m_valid && (bin_q == BIN_W'(N_BINS - 1));
    assign coef_err = coef_err_q;

`ifdef DFT_MAG_EN
    localparam int MAG_W = 2 * OUT_W;
    logic [MAG_W-1:0] mag_q;

    always_ff @(posedge clk) begin
        if (reset) mag_q <= '0;
        else       mag_q <= MAG_W'($signed(re_t)) * MAG_W'($signed(re_t))
                          + MAG_W'($signed(im_t)) * MAG_W'($signed(im_t));
    end

    assign m_mag = m_valid ? mag_q : '0;
`endif

endmodule

// File: tb/tb_dft_stream_engine.sv
// Self-checking bench for dft_stream_engine against a direct-sum DFT reference model.
module tb_dft_stream_engine;

    localparam int NP = 128;
    localparam int NB = 16;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int OW = DW + $clog2(NP) + 1;
`ifdef DFT_MAG_EN
    localparam int LAT = NP + 3;
`else
    localparam int LAT = NP + 2;
`endif

    logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, coef_we = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [6:0] coef_addr = '0;
    logic [CW-1:0] coef_cos = '0, coef_sin = '0;
    logic s_ready, coef_err, m_valid, m_last, busy;
    logic [3:0] m_bin;
    logic [OW-1:0] m_re, m_im;
`ifdef DFT_MAG_EN
    logic [2*OW-1:0] m_mag;
    logic [2*OW-1:0] got_mag [NB];
`endif

    int n_tests = 0, n_fail = 0, cyc = 0;
    int x_arr [NP];
    int tcos [NP], tsin [NP];
    logic [OW-1:0] exp_re [NB], exp_im [NB], got_re [NB], got_im [NB];
    logic [3:0] got_bin [NB];
    logic got_last [NB];
    int first_cyc [NB];

    dft_stream_engine dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_cos(coef_cos), .coef_sin(coef_sin),
        .coef_err(coef_err), .m_valid(m_valid), .m_ready(m_ready), .m_bin(m_bin),
        .m_re(m_re), .m_im(m_im), .m_last(m_last),
`ifdef DFT_MAG_EN
        .m_mag(m_mag),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        for (int m = 0; m < NP; m++) begin
            real a;
            a = 2.0 * 3.14159265358979 * m / NP;
            tcos[m] = int'(32767.0 * $cos(a));
            tsin[m] = int'(32767.0 * $sin(a));
            if (tcos[m] > 32767) tcos[m] = 32767;
            coef_we = 1'b1; coef_addr = m[6:0];
            coef_cos = tcos[m][CW-1:0]; coef_sin = tsin[m][CW-1:0];
            step();
        end
        coef_we = 1'b0;
    endtask

    // X[k] = sum x[n] * (cos - j sin)(2*pi*k*n/N), scaled down by 2^(CW-1) with floor.
    task automatic run_model();
        for (int k = 0; k < NB; k++) begin
            longint ar, ai;
            ar = 0; ai = 0;
            for (int n = 0; n < NP; n++) begin
                ar += longint'(x_arr[n]) * tcos[(k * n) % NP];
                ai -= longint'(x_arr[n]) * tsin[(k * n) % NP];
            end
            exp_re[k] = OW'(ar >>> (CW - 1));
            exp_im[k] = OW'(ai >>> (CW - 1));
        end
    endtask

    // Optionally rewrites twiddle entry 1 together with the last sample of the frame.
    task automatic send_frame(input bit gaps, input bit wr_last);
        for (int n = 0; n < NP; n++) begin
            if (gaps) while ($urandom_range(3) == 0) begin s_valid = 1'b0; step(); end
            s_valid = 1'b1; s_data = x_arr[n][DW-1:0];
            if (wr_last && n == NP - 1) begin
                tcos[1] = int'($urandom_range(65535)) - 32768;
                tsin[1] = int'($urandom_range(65535)) - 32768;
                coef_we = 1'b1; coef_addr = 7'd1;
                coef_cos = tcos[1][CW-1:0]; coef_sin = tsin[1][CW-1:0];
            end
            step();
            coef_we = 1'b0;
        end
        s_valid = 1'b0;
    endtask

    task automatic collect(input int ready_pct, input int nbins, output bit tmo);
        int nb, budget;
        nb = 0; budget = 0; tmo = 1'b0;
        for (int i = 0; i < NB; i++) first_cyc[i] = -1;
        while (nb < nbins && !tmo) begin
            m_ready = ($urandom_range(99) < ready_pct);
            if (m_valid && first_cyc[nb] < 0) first_cyc[nb] = cyc;
            if (m_valid && m_ready) begin
                got_bin[nb] = m_bin; got_re[nb] = m_re; got_im[nb] = m_im; got_last[nb] = m_last;
`ifdef DFT_MAG_EN
                got_mag[nb] = m_mag;
`endif
                nb++;
            end
            step();
            budget++;
            if (budget > 10000) tmo = 1'b1;
        end
        m_ready = 1'b0;
    endtask

    task automatic random_frame();
        for (int n = 0; n < NP; n++) x_arr[n] = int'($urandom_range(65535)) - 32768;
    endtask

    task automatic impulse_frame();
        for (int n = 0; n < NP; n++) x_arr[n] = 0;
        x_arr[0] = 1000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        n_tests++;
        if ({s_ready, m_valid, m_last, busy, coef_err} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=10000 (s_ready,m_valid,m_last,busy,coef_err)",
                     {s_ready, m_valid, m_last, busy, coef_err});
        end
        n_tests++;
        if ({m_bin, m_re, m_im} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got bin=%0d re=%0d im=%0d exp 0", m_bin, m_re, m_im);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_impulse(input string tag);
        bit tmo;
        int c0;
        impulse_frame();
        send_frame(1'b0, 1'b0);
        c0 = cyc;
        collect(100, NB, tmo);
        n_tests++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL %s_timeout got=%0d exp=0", tag, tmo); end
        n_tests++;
        if (first_cyc[0] - c0 !== LAT) begin
            n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", tag, first_cyc[0] - c0, LAT);
        end
        for (int k = 0; k < NB; k++) begin
            n_tests++;
            if (got_bin[k] !== k[3:0] || $signed(got_re[k]) !== 999 || got_im[k] !== '0
                || got_last[k] !== (k == NB - 1)) begin
                n_fail++;
                $display("FAIL %s_bin k=%0d got bin=%0d re=%0d im=%0d last=%b exp re=999 im=0 last=%b",
                         tag, k, got_bin[k], $signed(got_re[k]), $signed(got_im[k]), got_last[k], k == NB - 1);
            end
            if (k > 0) begin
                n_tests++;
                if (first_cyc[k] - first_cyc[k-1] !== LAT + 1) begin
                    n_fail++;
                    $display("FAIL %s_bin_period k=%0d got=%0d exp=%0d", tag, k,
                             first_cyc[k] - first_cyc[k-1], LAT + 1);
                end
            end
`ifdef DFT_MAG_EN
            n_tests++;
            if (got_mag[k] !== 998001) begin
                n_fail++; $display("FAIL %s_mag k=%0d got=%0d exp=998001", tag, k, got_mag[k]);
            end
`endif
        end
    endtask

    task automatic test_dc();
        bit tmo;
        int r, i;
        for (int n = 0; n < NP; n++) x_arr[n] = 1000;
        send_frame(1'b1, 1'b0);
        collect(100, NB, tmo);
        n_tests++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL dc_timeout got=%0d exp=0", tmo); end
        n_tests++;
        if ($signed(got_re[0]) !== 127996 || got_im[0] !== '0) begin
            n_fail++;
            $display("FAIL dc_bin0 got re=%0d im=%0d exp re=127996 im=0",
                     $signed(got_re[0]), $signed(got_im[0]));
        end
        for (int k = 1; k < NB; k++) begin
            r = $signed(got_re[k]); i = $signed(got_im[k]);
            n_tests++;
            if (r > 4 || r < -4 || i > 4 || i < -4 || got_bin[k] !== k[3:0]) begin
                n_fail++;
                $display("FAIL dc_leak k=%0d got bin=%0d re=%0d im=%0d exp |re|,|im|<=4", k, got_bin[k], r, i);
            end
        end
    endtask

    task automatic test_random(input int ready_pct, input bit gaps, input bit wr_last);
        bit tmo;
        random_frame();
        send_frame(gaps, wr_last);
        run_model();
        collect(ready_pct, NB, tmo);
        n_tests++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL random_timeout got=%0d exp=0", tmo); end
        for (int k = 0; k < NB; k++) begin
            n_tests++;
            if (got_bin[k] !== k[3:0] || got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k]
                || got_last[k] !== (k == NB - 1)) begin
                n_fail++;
                $display("FAIL random_bin k=%0d got bin=%0d re=%0d im=%0d last=%b exp re=%0d im=%0d",
                         k, got_bin[k], $signed(got_re[k]), $signed(got_im[k]), got_last[k],
                         $signed(exp_re[k]), $signed(exp_im[k]));
            end
        end
    endtask

    task automatic test_backpressure();
        int nb, hold, budget, hs_cyc;
        logic [4+2*OW:0] snap;
        random_frame();
        send_frame(1'b0, 1'b0);
        run_model();
        nb = 0; hold = 0; budget = 0; hs_cyc = 0; snap = '0;
        for (int i = 0; i < NB; i++) first_cyc[i] = -1;
        while (nb < NB && budget < 10000) begin
            m_ready = 1'b1;
            if (m_valid && first_cyc[nb] < 0) first_cyc[nb] = cyc;
            if (m_valid && m_bin == 4'd5 && hold < 10) begin
                m_ready = 1'b0;
                if (hold == 0) snap = {m_bin, m_re, m_im, m_last};
                else begin
                    n_tests++;
                    if ({m_bin, m_re, m_im, m_last} !== snap) begin
                        n_fail++;
                        $display("FAIL bp_stable hold=%0d got=%h exp=%h", hold, {m_bin, m_re, m_im, m_last}, snap);
                    end
                end
                hold++;
            end
            if (m_valid && m_ready) begin
                got_bin[nb] = m_bin; got_re[nb] = m_re; got_im[nb] = m_im;
                if (nb == 5) hs_cyc = cyc;
                nb++;
            end
            step();
            budget++;
        end
        m_ready = 1'b0;
        n_tests++;
        if (nb !== NB || hold !== 10) begin
            n_fail++; $display("FAIL bp_count got bins=%0d hold=%0d exp bins=%0d hold=10", nb, hold, NB);
        end
        // Handshake edge follows hs_cyc by one cycle; bin 6 appears LAT cycles after that edge.
        n_tests++;
        if (first_cyc[6] - hs_cyc !== LAT + 1) begin
            n_fail++; $display("FAIL bp_k6_latency got=%0d exp=%0d", first_cyc[6] - hs_cyc, LAT + 1);
        end
        for (int k = 0; k < NB; k++) begin
            n_tests++;
            if (got_bin[k] !== k[3:0] || got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k]) begin
                n_fail++;
                $display("FAIL bp_bin k=%0d got bin=%0d re=%0d im=%0d exp re=%0d im=%0d", k, got_bin[k],
                         $signed(got_re[k]), $signed(got_im[k]), $signed(exp_re[k]), $signed(exp_im[k]));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        impulse_frame();
        send_frame(1'b0, 1'b0);
        collect(100, 7, tmo);
        repeat (20) step();
        n_tests++;
        if (tmo !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre got tmo=%0d busy=%b exp tmo=0 busy=1", tmo, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if ({m_valid, s_ready, busy} !== 3'b010) begin
            n_fail++; $display("FAIL rmid_after got=%b exp=010 (m_valid,s_ready,busy)", {m_valid, s_ready, busy});
        end
        test_impulse("rmid_frame");
    endtask

    task automatic test_coef_err();
        bit tmo;
        random_frame();
        send_frame(1'b0, 1'b0);
        run_model();
        step(); step();
        n_tests++;
        if ({busy, coef_err} !== 2'b10) begin
            n_fail++; $display("FAIL cerr_pre got=%b exp=10 (busy,coef_err)", {busy, coef_err});
        end
        coef_we = 1'b1; coef_addr = 7'd3;
        coef_cos = ~tcos[3][CW-1:0]; coef_sin = ~tsin[3][CW-1:0];
        step();
        coef_we = 1'b0;
        n_tests++;
        if (coef_err !== 1'b1) begin n_fail++; $display("FAIL cerr_pulse got=%b exp=1", coef_err); end
        step();
        n_tests++;
        if (coef_err !== 1'b0) begin n_fail++; $display("FAIL cerr_clear got=%b exp=0", coef_err); end
        collect(100, NB, tmo);
        n_tests++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL cerr_timeout got=%0d exp=0", tmo); end
        for (int k = 0; k < NB; k++) begin
            n_tests++;
            if (got_re[k] !== exp_re[k] || got_im[k] !== exp_im[k]) begin
                n_fail++;
                $display("FAIL cerr_bin k=%0d got re=%0d im=%0d exp re=%0d im=%0d", k, $signed(got_re[k]),
                         $signed(got_im[k]), $signed(exp_re[k]), $signed(exp_im[k]));
            end
        end
    endtask

    initial begin
        test_reset();
        load_table();
        test_impulse("impulse");
        test_dc();
        test_random(100, 1'b1, 1'b0);
        test_random(60, 1'b1, 1'b1);
        test_backpressure();
        test_reset_mid();
        test_coef_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
